// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state encoding and IR field positions for the sequencer
package cpu_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    // IR field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_ROR  = 5'b00111;
    localparam opcode_t OP_ROL  = 5'b01000;
    localparam opcode_t OP_SHR  = 5'b01001;
    localparam opcode_t OP_SHRA = 5'b01010;
    localparam opcode_t OP_SHL  = 5'b01011;
    localparam opcode_t OP_ADDI = 5'b01100;
    localparam opcode_t OP_ANDI = 5'b01101;
    localparam opcode_t OP_ORI  = 5'b01110;
    localparam opcode_t OP_DIV  = 5'b01111;
    localparam opcode_t OP_MUL  = 5'b10000;
    localparam opcode_t OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_e;

    // Execute-phase families; each family shares one microstep recipe
    typedef enum logic [2:0] {
        CLS_REG,
        CLS_IMM,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_ILLEGAL
    } op_class_e;

    function automatic op_class_e op_class(input opcode_t op);
        op_class_e cls;
        cls = CLS_ILLEGAL;
        if (op >= OP_ADD && op <= OP_SHL) begin
            cls = CLS_REG;
        end else if (op >= OP_ADDI && op <= OP_ORI) begin
            cls = CLS_IMM;
        end else if (op == OP_DIV || op == OP_MUL) begin
            cls = CLS_MULDIV;
        end else if (op == OP_NEG || op == OP_NOT) begin
            cls = CLS_UNARY;
        end
        return cls;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - 4-bit register index plus enable to 16-bit one-hot strobe
module reg_select_decoder
    import cpu_pkg::*;
(
    input  logic [REG_IDX_W-1:0] sel_i,
    input  logic                 en_i,
    output logic [NUM_REGS-1:0]  onehot_o
);

    // Exactly one bit when enabled, none otherwise
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_source_sequencer.sv
// rtl/bus_source_sequencer.sv - fetch/execute microstep sequencer driving bus-source strobes and load enables
module bus_source_sequencer
    import cpu_pkg::*;
(
    input  logic                clock,
    input  logic                clear_n,
    input  logic                start,
    input  logic                stop,
    input  logic [DATA_W-1:0]   ir,
    input  logic                mem_ready,
    output logic [NUM_REGS-1:0] rOut,
    output logic                HIout,
    output logic                LOout,
    output logic                ZHIout,
    output logic                ZLOout,
    output logic                PCout,
    output logic                MDRout,
    output logic                InPortout,
    output logic                Cout,
    output logic [NUM_REGS-1:0] rIn,
    output logic                PCin,
    output logic                IRin,
    output logic                MARin,
    output logic                MDRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [4:0]          alu_op,
    output logic                running,
    output logic                err
);

    state_e    state_q, state_d;
    logic      t1_wait_q, t1_wait_d;
    opcode_t   opcode;
    op_class_e cls;
    logic [REG_IDX_W-1:0] ra, rb, rc;
    logic [REG_IDX_W-1:0] rout_sel, rin_sel;
    logic      rout_en, rin_en;
    logic      last_step;
    logic      unused_ir_low;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign ra     = ir[RA_MSB:RA_LSB];
    assign rb     = ir[RB_MSB:RB_LSB];
    assign rc     = ir[RC_MSB:RC_LSB];
    assign cls    = op_class(opcode);

    // Immediate/constant bits are consumed by the datapath, not the sequencer
    assign unused_ir_low = ^ir[RC_LSB-1:0];

    // State register; t1_wait_q marks T1 cycles after the first one
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= ST_IDLE;
            t1_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= t1_wait_d;
        end
    end

    // Next-state and per-step control strobes
    always_comb begin
        state_d   = state_q;
        last_step = 1'b0;
        rout_sel  = rb;
        rout_en   = 1'b0;
        rin_sel   = ra;
        rin_en    = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        ZHIout    = 1'b0;
        ZLOout    = 1'b0;
        PCout     = 1'b0;
        MDRout    = 1'b0;
        InPortout = 1'b0;
        Cout      = 1'b0;
        PCin      = 1'b0;
        IRin      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_T0;
                end
            end
            ST_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                // PC writeback happens once; only Read persists across the wait
                Read   = 1'b1;
                ZLOout = !t1_wait_q;
                PCin   = !t1_wait_q;
                if (mem_ready) begin
                    MDRin   = 1'b1;
                    state_d = ST_T2;
                end
            end
            ST_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = ST_T3;
            end
            ST_T3: begin
                state_d = ST_T4;
                case (cls)
                    CLS_REG, CLS_IMM: begin
                        rout_sel = rb;
                        rout_en  = 1'b1;
                        Yin      = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_sel = ra;
                        rout_en  = 1'b1;
                        Yin      = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout_sel = rb;
                        rout_en  = 1'b1;
                        Zin      = 1'b1;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_T4: begin
                state_d = ST_T5;
                case (cls)
                    CLS_REG: begin
                        rout_sel = rc;
                        rout_en  = 1'b1;
                        Zin      = 1'b1;
                    end
                    CLS_IMM: begin
                        Cout = 1'b1;
                        Zin  = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_sel = rb;
                        rout_en  = 1'b1;
                        Zin      = 1'b1;
                    end
                    CLS_UNARY: begin
                        ZLOout    = 1'b1;
                        rin_en    = 1'b1;
                        last_step = 1'b1;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_REG, CLS_IMM: begin
                        ZLOout    = 1'b1;
                        rin_en    = 1'b1;
                        last_step = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ZLOout  = 1'b1;
                        LOin    = 1'b1;
                        state_d = ST_T6;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_T6: begin
                ZHIout    = 1'b1;
                HIin      = 1'b1;
                last_step = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (last_step) begin
            state_d = stop ? ST_IDLE : ST_T0;
        end

        t1_wait_d = (state_q == ST_T1) && (state_d == ST_T1);
    end

    // Status and ALU opcode forwarding; the fetch-time Zin (PC increment) carries no opcode
    always_comb begin
        running = (state_q != ST_IDLE) && (state_q != ST_HALT);
        err     = (state_q == ST_HALT);
        alu_op  = '0;
        if (Zin && (state_q inside {ST_T3, ST_T4, ST_T5, ST_T6})) begin
            alu_op = opcode;
        end
    end

    reg_select_decoder u_rout_dec (
        .sel_i    (rout_sel),
        .en_i     (rout_en),
        .onehot_o (rOut)
    );

    reg_select_decoder u_rin_dec (
        .sel_i    (rin_sel),
        .en_i     (rin_en),
        .onehot_o (rIn)
    );

endmodule
